cpu_seq_datapath: RTL and testbench

CPU_SEQ_DATAPATH -- requirements
Module: cpu_seq_datapath

---
 rtl/cpu_seq_datapath.sv | 253 +++++++++++++++++++++++++
 tb/tb_cpu_seq_datapath.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_datapath.sv
// cpu_seq_datapath: multi-cycle accumulator CPU with one request/ack memory port.
// Define CPU_ISZ_EN to implement ISZ (opcode 6); otherwise opcode 6 retires as a NOP.
module cpu_seq_datapath #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              i_clr_reg,
    input  logic              i_start,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic [AWIDTH-1:0] o_pc,
    output logic [DWIDTH-1:0] o_ac,
    output logic [DWIDTH-1:0] o_ir,
    output logic              o_e,
    output logic              o_halt,
    output logic              o_instr_done
);

    generate
        if (DWIDTH != AWIDTH + 4 || DWIDTH < 16 || DWIDTH > 32) begin : g_param_check
            $error("cpu_seq_datapath: DWIDTH must be AWIDTH+4 and within 16..32");
        end
    endgenerate

`ifdef CPU_ISZ_EN
    localparam logic ISZ_EN = 1'b1;
`else
    localparam logic ISZ_EN = 1'b0;
`endif

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DECODE   = 3'd2;
    localparam logic [2:0] ST_INDIRECT = 3'd3;
    localparam logic [2:0] ST_OPRD     = 3'd4;
    localparam logic [2:0] ST_EXEC     = 3'd5;
    localparam logic [2:0] ST_OPWR     = 3'd6;
    localparam logic [2:0] ST_HALT     = 3'd7;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_LDA  = 3'd2;
    localparam logic [2:0] OP_STA  = 3'd3;
    localparam logic [2:0] OP_BUN  = 3'd4;
    localparam logic [2:0] OP_BSA  = 3'd5;
    localparam logic [2:0] OP_ISZ  = 3'd6;
    localparam logic [2:0] OP_RREF = 3'd7;

    localparam logic [AWIDTH-1:0] A_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DWIDTH-1:0] D_ONE = {{(DWIDTH-1){1'b0}}, 1'b1};

    logic [2:0]        state_r;
    logic [DWIDTH-1:0] ir_r;
    logic [DWIDTH-1:0] dr_r;
    logic [DWIDTH-1:0] ac_r;
    logic [AWIDTH-1:0] ar_r;
    logic [AWIDTH-1:0] pc_r;
    logic              e_r;
    logic              req_r;
    logic              we_r;
    logic [DWIDTH-1:0] wdata_r;
    logic              halt_r;
    logic              done_r;

    logic              ind_s;
    logic [2:0]        opcode_s;
    logic              needs_opnd_s;
    logic [2:0]        retire_state_s;
    logic [DWIDTH:0]   rr_s;
    logic              rr_skip_s;

    // Register-reference micro-ops applied in fixed order; result is {E, AC}.
    function automatic logic [DWIDTH:0] reg_ref(input logic [11:0] op,
                                                input logic [DWIDTH-1:0] ac,
                                                input logic e);
        logic [DWIDTH-1:0] a;
        logic              c;
        a = op[11] ? {DWIDTH{1'b0}} : ac;
        c = op[10] ? 1'b0 : e;
        a = op[9] ? ~a : a;
        c = op[8] ? ~c : c;
        {a, c} = op[7] ? {c, a} : {a, c};
        {c, a} = op[6] ? {a, c} : {c, a};
        a = op[5] ? a + D_ONE : a;
        return {c, a};
    endfunction

    assign ind_s          = ir_r[DWIDTH-1];
    assign opcode_s       = ir_r[DWIDTH-2:DWIDTH-4];
    assign needs_opnd_s   = (opcode_s == OP_AND) || (opcode_s == OP_ADD) ||
                            (opcode_s == OP_LDA) || (opcode_s == OP_ISZ);
    assign retire_state_s = i_start ? ST_FETCH : ST_IDLE;
    assign rr_s           = reg_ref(ir_r[11:0], ac_r, e_r);
    // Skip tests look at AC/E before this instruction modifies them.
    assign rr_skip_s      = (ir_r[4] & ~ac_r[DWIDTH-1]) | (ir_r[3] & ac_r[DWIDTH-1]) |
                            (ir_r[2] & (ac_r == {DWIDTH{1'b0}})) | (ir_r[1] & ~e_r);

    // Instruction sequencer and all architectural/port registers.
    always_ff @(posedge clk or posedge i_clr_reg) begin
        if (i_clr_reg) begin
            state_r <= ST_IDLE;
            ir_r    <= {DWIDTH{1'b0}};
            dr_r    <= {DWIDTH{1'b0}};
            ac_r    <= {DWIDTH{1'b0}};
            ar_r    <= {AWIDTH{1'b0}};
            pc_r    <= {AWIDTH{1'b0}};
            e_r     <= 1'b0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            wdata_r <= {DWIDTH{1'b0}};
            halt_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= i_start ? ST_FETCH : ST_IDLE;
                end
                ST_FETCH: begin
                    if (!req_r) begin
                        ar_r  <= pc_r;
                        req_r <= 1'b1;
                        we_r  <= 1'b0;
                    end else if (i_mem_ack) begin
                        req_r   <= 1'b0;
                        ir_r    <= i_mem_rdata;
                        pc_r    <= pc_r + A_ONE;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ar_r <= ir_r[AWIDTH-1:0];
                    if (opcode_s == OP_ISZ && !ISZ_EN) begin
                        done_r  <= 1'b1;
                        state_r <= retire_state_s;
                    end else if (ind_s && opcode_s != OP_RREF) begin
                        state_r <= ST_INDIRECT;
                    end else if (needs_opnd_s) begin
                        state_r <= ST_OPRD;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_INDIRECT: begin
                    if (!req_r) begin
                        req_r <= 1'b1;
                    end else if (i_mem_ack) begin
                        req_r   <= 1'b0;
                        ar_r    <= i_mem_rdata[AWIDTH-1:0];
                        state_r <= needs_opnd_s ? ST_OPRD : ST_EXEC;
                    end
                end
                ST_OPRD: begin
                    if (!req_r) begin
                        req_r <= 1'b1;
                    end else if (i_mem_ack) begin
                        req_r   <= 1'b0;
                        dr_r    <= i_mem_rdata;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opcode_s)
                        OP_AND: begin
                            ac_r    <= ac_r & dr_r;
                            done_r  <= 1'b1;
                            state_r <= retire_state_s;
                        end
                        OP_ADD: begin
                            {e_r, ac_r} <= {1'b0, ac_r} + {1'b0, dr_r};
                            done_r      <= 1'b1;
                            state_r     <= retire_state_s;
                        end
                        OP_LDA: begin
                            ac_r    <= dr_r;
                            done_r  <= 1'b1;
                            state_r <= retire_state_s;
                        end
                        OP_BUN: begin
                            pc_r    <= ar_r;
                            done_r  <= 1'b1;
                            state_r <= retire_state_s;
                        end
                        OP_STA: begin
                            wdata_r <= ac_r;
                            state_r <= ST_OPWR;
                        end
                        OP_BSA: begin
                            wdata_r <= {{(DWIDTH-AWIDTH){1'b0}}, pc_r};
                            state_r <= ST_OPWR;
                        end
                        OP_ISZ: begin
                            dr_r    <= dr_r + D_ONE;
                            wdata_r <= dr_r + D_ONE;
                            state_r <= ST_OPWR;
                        end
                        OP_RREF: begin
                            {e_r, ac_r} <= rr_s;
                            pc_r        <= rr_skip_s ? pc_r + A_ONE : pc_r;
                            halt_r      <= ir_r[0];
                            done_r      <= 1'b1;
                            state_r     <= ir_r[0] ? ST_HALT : retire_state_s;
                        end
                        default: begin
                            done_r  <= 1'b1;
                            state_r <= retire_state_s;
                        end
                    endcase
                end
                ST_OPWR: begin
                    if (!req_r) begin
                        req_r <= 1'b1;
                        we_r  <= 1'b1;
                    end else if (i_mem_ack) begin
                        req_r   <= 1'b0;
                        we_r    <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= retire_state_s;
                        // BSA returns past the stored link; ISZ skips once the write lands.
                        if (opcode_s == OP_BSA) begin
                            pc_r <= ar_r + A_ONE;
                        end else if (opcode_s == OP_ISZ && dr_r == {DWIDTH{1'b0}}) begin
                            pc_r <= pc_r + A_ONE;
                        end
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req    = req_r;
    assign o_mem_we     = we_r;
    assign o_mem_addr   = ar_r;
    assign o_mem_wdata  = wdata_r;
    assign o_pc         = pc_r;
    assign o_ac         = ac_r;
    assign o_ir         = ir_r;
    assign o_e          = e_r;
    assign o_halt       = halt_r;
    assign o_instr_done = done_r;

endmodule

// File: tb/tb_cpu_seq_datapath.sv
// Directed testbench for cpu_seq_datapath with a latency-programmable memory responder.
module tb_cpu_seq_datapath;

    logic        clk = 1'b0;
    logic        i_clr_reg = 1'b0;
    logic        i_start = 1'b0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [11:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [11:0] o_pc;
    logic [15:0] o_ac;
    logic [15:0] o_ir;
    logic        o_e;
    logic        o_halt;
    logic        o_instr_done;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int inject_req = 0;

    logic [15:0] mem [0:4095];

    int          inject_seen = 0;
    int          wait_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [11:0] rd_addr [0:255];
    logic [11:0] wr_addr [0:255];
    logic [15:0] wr_data [0:255];

    cpu_seq_datapath dut (
        .clk          (clk),
        .i_clr_reg    (i_clr_reg),
        .i_start      (i_start),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ack    (mem_ack),
        .o_pc         (o_pc),
        .o_ac         (o_ac),
        .o_ir         (o_ir),
        .o_e          (o_e),
        .o_halt       (o_halt),
        .o_instr_done (o_instr_done)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after 'lat' negedges of an outstanding request, logs accesses.
    initial begin : mem_model
        forever begin
            @(negedge clk);
            if (o_instr_done) done_cnt++;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (inject_seen != inject_req) begin
                inject_seen = inject_req;
                mem_ack     = 1'b1;
                mem_rdata   = 16'hDEAD;
            end else if (o_mem_req) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    if (o_mem_we) begin
                        if (wr_cnt < 256) begin
                            wr_addr[wr_cnt] = o_mem_addr;
                            wr_data[wr_cnt] = o_mem_wdata;
                        end
                        wr_cnt++;
                    end else begin
                        mem_rdata = mem[o_mem_addr];
                        if (rd_cnt < 256) rd_addr[rd_cnt] = o_mem_addr;
                        rd_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        i_start   = 1'b0;
        i_clr_reg = 1'b1;
        repeat (2) @(negedge clk);
        i_clr_reg = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    // Runs until n retires (or halt); i_start drops once the last instruction is under way.
    task automatic run_prog(input int n, input string name);
        int cnt = 0;
        int cyc = 0;
        i_start = 1'b1;
        while (cnt < n && !o_halt && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (o_instr_done) cnt++;
            if (cnt >= n - 1) i_start = 1'b0;
        end
        i_start = 1'b0;
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL %s_timeout: retired %0d, required %0d within budget", name, cnt, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        i_clr_reg = 1'b1;
        #1;
        checks++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_pc, o_ac, o_ir, o_e, o_halt, o_instr_done} !== 85'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pc=%h ac=%h ir=%h req=%b, required all zero", o_pc, o_ac, o_ir, o_mem_req);
        end
        repeat (2) @(negedge clk);
        i_clr_reg = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: req=%b, required 0", o_mem_req);
        end
    endtask

    task automatic test_lda();
        int d0;
        int r0;
        clear_mem();
        mem[0] = 16'h2005;
        mem[5] = 16'h1234;
        lat = 1;
        do_reset();
        d0 = done_cnt;
        r0 = rd_cnt;
        run_prog(1, "lda");
        checks++;
        if (o_ac !== 16'h1234) begin errors++; $display("FAIL lda_ac: got %h, required 1234", o_ac); end
        checks++;
        if (o_pc !== 12'h001) begin errors++; $display("FAIL lda_pc: got %h, required 001", o_pc); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL lda_done_count: got %0d, required 1", done_cnt - d0); end
        checks++;
        if (rd_cnt - r0 !== 2) begin errors++; $display("FAIL lda_reads: got %0d, required 2", rd_cnt - r0); end
    endtask

    task automatic test_indirect();
        int r0;
        clear_mem();
        mem[0] = 16'hA005;
        mem[5] = 16'h0007;
        mem[7] = 16'hBEEF;
        lat = 3;
        do_reset();
        r0 = rd_cnt;
        run_prog(1, "indirect");
        checks++;
        if (o_ac !== 16'hBEEF) begin errors++; $display("FAIL ind_ac: got %h, required beef", o_ac); end
        checks++;
        if (rd_cnt - r0 !== 3) begin errors++; $display("FAIL ind_reads: got %0d, required 3", rd_cnt - r0); end
        checks++;
        if ({rd_addr[r0], rd_addr[r0+1], rd_addr[r0+2]} !== {12'h000, 12'h005, 12'h007}) begin
            errors++;
            $display("FAIL ind_order: got %h,%h,%h, required 000,005,007", rd_addr[r0], rd_addr[r0+1], rd_addr[r0+2]);
        end
        lat = 1;
    endtask

    task automatic test_add_carry();
        clear_mem();
        mem[0]  = 16'h200A;
        mem[1]  = 16'h100B;
        mem[10] = 16'hFFFF;
        mem[11] = 16'h0001;
        do_reset();
        run_prog(2, "add");
        checks++;
        if (o_ac !== 16'h0000) begin errors++; $display("FAIL add_ac: got %h, required 0000", o_ac); end
        checks++;
        if (o_e !== 1'b1) begin errors++; $display("FAIL add_carry: got %b, required 1", o_e); end
        checks++;
        if (o_pc !== 12'h002) begin errors++; $display("FAIL add_pc: got %h, required 002", o_pc); end
    endtask

    task automatic test_isz();
        int r0;
        int w0;
        clear_mem();
        mem[0] = 16'h4003;
        mem[3] = 16'h6009;
        mem[9] = 16'hFFFF;
        do_reset();
        r0 = rd_cnt;
        w0 = wr_cnt;
        run_prog(2, "isz");
`ifdef CPU_ISZ_EN
        checks++;
        if (o_pc !== 12'h005) begin errors++; $display("FAIL isz_pc: got %h, required 005", o_pc); end
        checks++;
        if (wr_cnt - w0 !== 1 || wr_addr[w0] !== 12'h009 || wr_data[w0] !== 16'h0000) begin
            errors++;
            $display("FAIL isz_write: got %0d writes (%h<=%h), required 1 write 009<=0000", wr_cnt - w0, wr_addr[w0], wr_data[w0]);
        end
        checks++;
        if (rd_cnt - r0 !== 3) begin errors++; $display("FAIL isz_reads: got %0d, required 3", rd_cnt - r0); end
`else
        checks++;
        if (o_pc !== 12'h004) begin errors++; $display("FAIL isz_nop_pc: got %h, required 004", o_pc); end
        checks++;
        if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL isz_nop_write: got %0d writes, required 0", wr_cnt - w0); end
        checks++;
        if (rd_cnt - r0 !== 2) begin errors++; $display("FAIL isz_nop_reads: got %0d, required 2", rd_cnt - r0); end
`endif
    endtask

    task automatic test_store_branch();
        int w0;
        clear_mem();
        mem[0]     = 16'h200A;
        mem[1]     = 16'h3014;
        mem[2]     = 16'h5030;
        mem[12'h31] = 16'h7001;
        mem[10]    = 16'h5A5A;
        do_reset();
        w0 = wr_cnt;
        run_prog(10, "sta_bsa");
        checks++;
        if (wr_cnt - w0 !== 2 || wr_addr[w0] !== 12'h014 || wr_data[w0] !== 16'h5A5A) begin
            errors++;
            $display("FAIL sta_write: got %0d writes, first %h<=%h, required 014<=5a5a", wr_cnt - w0, wr_addr[w0], wr_data[w0]);
        end
        checks++;
        if (wr_addr[w0+1] !== 12'h030 || wr_data[w0+1] !== 16'h0003) begin
            errors++;
            $display("FAIL bsa_link: got %h<=%h, required 030<=0003", wr_addr[w0+1], wr_data[w0+1]);
        end
        checks++;
        if (o_pc !== 12'h032 || o_halt !== 1'b1) begin
            errors++;
            $display("FAIL bsa_pc: got pc=%h halt=%b, required pc=032 halt=1", o_pc, o_halt);
        end
    endtask

    task automatic test_regref_halt();
        int r0;
        int d0;
        clear_mem();
        mem[0] = 16'h7100;
        mem[1] = 16'h7840;
        mem[2] = 16'h7001;
        do_reset();
        run_prog(10, "regref");
        checks++;
        if (o_ac !== 16'h0001 || o_e !== 1'b0) begin
            errors++;
            $display("FAIL rr_ac: got ac=%h e=%b, required ac=0001 e=0", o_ac, o_e);
        end
        checks++;
        if (o_halt !== 1'b1 || o_pc !== 12'h003) begin
            errors++;
            $display("FAIL rr_halt: got halt=%b pc=%h, required halt=1 pc=003", o_halt, o_pc);
        end
        r0 = rd_cnt;
        d0 = done_cnt;
        i_start = 1'b1;
        repeat (20) @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (rd_cnt !== r0 || done_cnt !== d0 || o_halt !== 1'b1) begin
            errors++;
            $display("FAIL halt_stops_fetch: got %0d new reads %0d retires halt=%b, required 0 0 1", rd_cnt - r0, done_cnt - d0, o_halt);
        end
    endtask

    task automatic test_skip_tests();
        clear_mem();
        mem[0]  = 16'h200A;
        mem[1]  = 16'h000B;
        mem[2]  = 16'h7004;
        mem[3]  = 16'h7210;
        mem[4]  = 16'h7001;
        mem[5]  = 16'h7001;
        mem[10] = 16'h00F0;
        mem[11] = 16'h0FF0;
        do_reset();
        run_prog(10, "skip");
        checks++;
        if (o_ac !== 16'hFF0F) begin errors++; $display("FAIL skip_ac: got %h, required ff0f", o_ac); end
        checks++;
        if (o_pc !== 12'h006) begin errors++; $display("FAIL skip_pc: got %h, required 006", o_pc); end
    endtask

    task automatic test_clr_mid_request();
        int cyc = 0;
        int d0;
        int r0;
        clear_mem();
        mem[0] = 16'h2005;
        mem[1] = 16'h2005;
        mem[5] = 16'h1234;
        lat = 1;
        do_reset();
        run_prog(1, "pre_clr");
        lat = 1000;
        i_start = 1'b1;
        while (!o_mem_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 12'h001) begin
            errors++;
            $display("FAIL clr_setup: got req=%b addr=%h, required req=1 addr=001", o_mem_req, o_mem_addr);
        end
        #2;
        i_clr_reg = 1'b1;
        #1;
        checks++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_pc, o_ac, o_ir, o_e, o_halt, o_instr_done} !== 85'd0) begin
            errors++;
            $display("FAIL clr_immediate: got req=%b pc=%h ac=%h ir=%h, required all zero", o_mem_req, o_pc, o_ac, o_ir);
        end
        i_start = 1'b0;
        @(negedge clk);
        i_clr_reg = 1'b0;
        d0 = done_cnt;
        inject_req++;
        repeat (6) @(negedge clk);
        checks++;
        if (o_ir !== 16'h0000 || o_pc !== 12'h000 || o_mem_req !== 1'b0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL late_ack_ignored: got ir=%h pc=%h req=%b retires=%0d, required 0 0 0 0", o_ir, o_pc, o_mem_req, done_cnt - d0);
        end
        lat = 1;
        r0 = rd_cnt;
        run_prog(1, "restart");
        checks++;
        if (rd_addr[r0] !== 12'h000 || o_ac !== 16'h1234 || o_pc !== 12'h001) begin
            errors++;
            $display("FAIL clr_restart: got first read %h ac=%h pc=%h, required 000 1234 001", rd_addr[r0], o_ac, o_pc);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_indirect();
        test_add_carry();
        test_isz();
        test_store_branch();
        test_regref_halt();
        test_skip_tests();
        test_clr_mid_request();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
